mod12_event_monitor: RTL and testbench
======================================

MOD12_EVENT_MONITOR -- requirements
Module: mod12_event_monitor

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter CNT_W, default 8, width of wrap_count.
REQ-003 SHALL have port clock, input, 1, sole clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port count_in, input, 4, mod-12 counter output sampled every cycle.
REQ-006 SHALL have port evt_valid, output, 1, FIFO non-empty.
REQ-007 SHALL have port evt_ready, input, 1, consumer accepts head entry.
REQ-008 SHALL have port evt_data, output, 8, FIFO head record.
REQ-009 SHALL have port wrap_count, output, CNT_W, saturating total of up-wraps plus down-wraps.
REQ-010 SHALL have port range_err, output, 1, registered flag: last sample was greater than 11.
REQ-011 SHALL have port drop_sticky, output, 1, at least one event lost because the FIFO was full.

Function
REQ-012 SHALL register count_in into prev_count each cycle and set prime_q after the first post-reset sample; no event is classified while prime_q=0.
REQ-013 SHALL classify each primed cycle as range error when count_in>11.
REQ-014 Otherwise, SHALL classify it as up-wrap when prev=11 and cur=0.
REQ-015 Otherwise, SHALL classify it as down-wrap when prev=0 and cur=11.
REQ-016 Otherwise, SHALL classify it as jump when cur is not prev, prev+1 or prev-1 (mod 12), or when prev>11.
REQ-017 SHALL apply priority range error > up-wrap > down-wrap > jump, producing at most one event per cycle.
REQ-018 SHALL format evt_data as [7:6] type (00 up-wrap, 01 down-wrap, 10 jump, 11 range error), [5:4] = 0, [3:0] = cur value.
REQ-019 SHALL push the event on the same clock edge it is classified; the earliest evt_valid is 1 cycle after count_in changes.
REQ-020 SHALL pop on evt_valid and evt_ready; evt_data SHALL hold stable while evt_valid=1 and evt_ready=0.
REQ-021 When full with a simultaneous pop, SHALL accept the push; occupancy stays FIFO_DEPTH.
REQ-022 When full without a pop, SHALL drop the new event and set drop_sticky; the FIFO contents stay unchanged.
REQ-023 SHALL ignore a pop when empty; SHALL ignore evt_ready when evt_valid=0.
REQ-024 SHALL increment wrap_count on every up-wrap or down-wrap event, including dropped ones, and saturate at 2^CNT_W-1.
REQ-025 SHALL update range_err every cycle from count_in>11, regardless of prime_q.

Reset
REQ-026 On reset assertion, SHALL asynchronously clear FIFO pointers, evt_valid, wrap_count, range_err, drop_sticky, prev_count and prime_q.
REQ-027 evt_data SHALL read 8'h00 while the FIFO is empty.
REQ-028 Reset asserted mid-operation SHALL discard all queued events; the first post-reset sample SHALL NOT produce an event.
REQ-029 drop_sticky SHALL clear only on reset.

Configuration
REQ-030 With macro MOD12_MON_JUMP_EN defined, SHALL generate jump events per REQ-016.
REQ-031 Without MOD12_MON_JUMP_EN, SHALL suppress jump events and push only wrap and range-error events; all other behaviour is unchanged.

Structure
REQ-032 SHALL take the event-type enum, MOD12_MAX=11 and EVT_W=8 from package mod12_mon_pkg.
REQ-033 SHALL implement storage in sub-module mod12_mon_fifo (synchronous FIFO with full/empty flags and asynchronous reset); classification logic stays in the top module.

Verification
REQ-034 Drive count_in 9,10,11,0,1 with evt_ready=1 -> one entry 8'h00, wrap_count=1.
REQ-035 Drive count_in 1,0,11,10 -> one entry 8'h4B, wrap_count increments by 1.
REQ-036 Drive count_in 3 then 7 -> entry 8'h87 with the macro defined; no entry without it.
REQ-037 Drive count_in 5 then 13 -> entry 8'hCD, range_err=1 the next cycle; drive 0 next -> jump entry 8'h80 (macro defined), no up-wrap.
REQ-038 Hold evt_ready=0 with FIFO_DEPTH=4 and cause 5 wraps -> 4 entries held, drop_sticky=1, wrap_count=5.
REQ-039 Hold evt_ready=0 and queue 3 entries, assert reset for 1 cycle -> evt_valid=0, wrap_count=0; next sample (count_in=0) -> no event.

Source files
------------

// File: rtl/mod12_mon_pkg.sv
// Shared types and constants for the mod-12 event monitor.
// Event record layout: [7:6] event type, [5:4] zero, [3:0] sampled count value.
package mod12_mon_pkg;

  localparam logic [3:0] MOD12_MAX = 4'd11;
  localparam int         EVT_W     = 8;

  typedef enum logic [1:0] {
    EVT_UP_WRAP   = 2'b00,
    EVT_DOWN_WRAP = 2'b01,
    EVT_JUMP      = 2'b10,
    EVT_RANGE_ERR = 2'b11
  } evt_type_e;

  // Pack an event type and the sampled count into one FIFO record.
  function automatic logic [EVT_W-1:0] make_evt(input evt_type_e t, input logic [3:0] cur);
    make_evt = {t, 2'b00, cur};
  endfunction

endpackage

// File: rtl/mod12_mon_fifo.sv
// Synchronous FIFO holding event records for the mod-12 event monitor.
// Handshake: a pop happens only when pop=1 and the FIFO is non-empty; a push
// is accepted when the FIFO is not full, or when it is full and a pop happens
// on the same edge. head_data reads zero while empty.
module mod12_mon_fifo import mod12_mon_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [EVT_W-1:0] push_data,
  input  logic             pop,
  output logic [EVT_W-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [EVT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Storage array: written on accepted pushes, never reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mod12_event_monitor.sv
// Mod-12 counter event monitor: classifies each sampled count transition as
// up-wrap, down-wrap, jump or range error and queues one record per event.
// Optional feature macro MOD12_MON_JUMP_EN: when defined, jump events are
// generated; otherwise only wrap and range-error events are queued.
// Handshake: evt_valid=1 whenever a record is queued; the head record is
// consumed on a rising edge with evt_valid=1 and evt_ready=1, and evt_data
// holds stable while evt_valid=1 and evt_ready=0.
module mod12_event_monitor import mod12_mon_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       count_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [EVT_W-1:0] evt_data,
  output logic [CNT_W-1:0] wrap_count,
  output logic             range_err,
  output logic             drop_sticky
);

`ifdef MOD12_MON_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  logic [3:0]       prev_count;
  logic             prime_q;
  logic [3:0]       prev_inc;
  logic [3:0]       prev_dec;
  logic             cur_range;
  logic             jump_raw;
  logic             evt_hit;
  logic             is_wrap;
  evt_type_e        evt_type;
  logic [EVT_W-1:0] evt_record;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  assign cur_range = (count_in > MOD12_MAX);
  assign prev_inc  = (prev_count == MOD12_MAX) ? 4'd0 : prev_count + 4'd1;
  assign prev_dec  = (prev_count == 4'd0) ? MOD12_MAX : prev_count - 4'd1;
  assign jump_raw  = (prev_count > MOD12_MAX) ||
                     ((count_in != prev_count) && (count_in != prev_inc) &&
                      (count_in != prev_dec));

  // Prioritised classification of the current sample against the previous one.
  always_comb begin
    evt_hit  = 1'b0;
    is_wrap  = 1'b0;
    evt_type = EVT_JUMP;
    if (prime_q) begin
      if (cur_range) begin
        evt_hit  = 1'b1;
        evt_type = EVT_RANGE_ERR;
      end else if (prev_count == MOD12_MAX && count_in == 4'd0) begin
        evt_hit  = 1'b1;
        is_wrap  = 1'b1;
        evt_type = EVT_UP_WRAP;
      end else if (prev_count == 4'd0 && count_in == MOD12_MAX) begin
        evt_hit  = 1'b1;
        is_wrap  = 1'b1;
        evt_type = EVT_DOWN_WRAP;
      end else if (JUMP_EN && jump_raw) begin
        evt_hit  = 1'b1;
        evt_type = EVT_JUMP;
      end
    end
  end

  assign evt_record = make_evt(evt_type, count_in);
  assign evt_valid  = !fifo_empty;
  assign pop        = evt_valid && evt_ready;

  mod12_mon_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (evt_hit),
    .push_data (evt_record),
    .pop       (pop),
    .head_data (evt_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sample history, wrap counter, range flag and drop flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_count  <= '0;
      prime_q     <= 1'b0;
      wrap_count  <= '0;
      range_err   <= 1'b0;
      drop_sticky <= 1'b0;
    end else begin
      prev_count <= count_in;
      prime_q    <= 1'b1;
      range_err  <= cur_range;
      if (is_wrap && (wrap_count != {CNT_W{1'b1}})) wrap_count <= wrap_count + 1'b1;
      if (evt_hit && fifo_full && !pop) drop_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mod12_event_monitor.sv
// Self-checking bench for mod12_event_monitor (default parameters).
// Optional feature macro MOD12_MON_JUMP_EN changes the expected jump records.
module tb_mod12_event_monitor;

  localparam int DEPTH = 4;
  localparam int CW    = 8;

`ifdef MOD12_MON_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    count_in = 4'd0;
  logic          evt_ready = 1'b0;
  logic          evt_valid;
  logic [7:0]    evt_data;
  logic [CW-1:0] wrap_count;
  logic          range_err;
  logic          drop_sticky;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  mod12_event_monitor #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .count_in    (count_in),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_data    (evt_data),
    .wrap_count  (wrap_count),
    .range_err   (range_err),
    .drop_sticky (drop_sticky)
  );

  // Clock generation.
  always #5 clock = ~clock;

  // Behavioural model: event queue plus counters, updated on each sampled edge.
  logic [7:0] exp_q[$];
  int m_prev  = 0;
  bit m_prime = 1'b0;
  int m_wraps = 0;
  bit m_drop  = 1'b0;
  bit m_range = 1'b0;

  always @(posedge clock or posedge reset) begin : model
    int c;
    int diff;
    int typ;
    if (reset) begin
      exp_q.delete();
      m_prev  = 0;
      m_prime = 1'b0;
      m_wraps = 0;
      m_drop  = 1'b0;
      m_range = 1'b0;
    end else begin
      c   = int'(count_in);
      typ = -1;
      if (exp_q.size() > 0 && evt_ready) void'(exp_q.pop_front());
      if (m_prime) begin
        if (c > 11) typ = 3;
        else if (m_prev == 11 && c == 0) typ = 0;
        else if (m_prev == 0 && c == 11) typ = 1;
        else if (JUMP_EN) begin
          if (m_prev > 11) typ = 2;
          else begin
            diff = (c - m_prev + 12) % 12;
            if (!(diff == 0 || diff == 1 || diff == 11)) typ = 2;
          end
        end
      end
      if (typ >= 0) begin
        if (typ <= 1 && m_wraps < (1 << CW) - 1) m_wraps++;
        if (exp_q.size() < DEPTH) exp_q.push_back(8'(typ * 64 + c));
        else m_drop = 1'b1;
      end
      m_range = (c > 11);
      m_prev  = c;
      m_prime = 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("mdl_evt_valid", int'(evt_valid), int'(exp_q.size() != 0));
      check("mdl_evt_data", int'(evt_data), (exp_q.size() != 0) ? int'(exp_q[0]) : 0);
      check("mdl_wrap_count", int'(wrap_count), m_wraps);
      check("mdl_range_err", int'(range_err), int'(m_range));
      check("mdl_drop_sticky", int'(drop_sticky), int'(m_drop));
    end
  end

  // Apply one sample; returns at the following falling edge.
  task automatic drive(input logic [3:0] c);
    count_in = c;
    @(negedge clock);
  endtask

  // Reset pulse asserted mid-cycle, released on a falling edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Reset state.
    check("rst_valid", int'(evt_valid), 0);
    check("rst_data", int'(evt_data), 0);
    check("rst_wrap", int'(wrap_count), 0);
    check("rst_range", int'(range_err), 0);
    check("rst_drop", int'(drop_sticky), 0);

    // Up-wrap 9,10,11,0,1.
    do_reset();
    evt_ready = 1'b1;
    drive(4'd9); drive(4'd10); drive(4'd11);
    check("up_pre_valid", int'(evt_valid), 0);
    drive(4'd0);
    check("up_valid", int'(evt_valid), 1);
    check("up_data", int'(evt_data), 8'h00);
    check("up_wrap", int'(wrap_count), 1);
    drive(4'd1);
    check("up_popped", int'(evt_valid), 0);

    // Down-wrap 1,0,11,10.
    do_reset();
    drive(4'd1); drive(4'd0); drive(4'd11);
    check("dn_valid", int'(evt_valid), 1);
    check("dn_data", int'(evt_data), 8'h4B);
    check("dn_wrap", int'(wrap_count), 1);
    drive(4'd10);
    check("dn_after_valid", int'(evt_valid), 0);
    check("dn_after_wrap", int'(wrap_count), 1);

    // Jump 3 -> 7.
    do_reset();
    drive(4'd3); drive(4'd7);
`ifdef MOD12_MON_JUMP_EN
    check("jump_valid", int'(evt_valid), 1);
    check("jump_data", int'(evt_data), 8'h87);
`else
    check("jump_valid", int'(evt_valid), 0);
    check("jump_data", int'(evt_data), 8'h00);
`endif
    drive(4'd7);

    // Range error 5 -> 13, then 0 (jump, not up-wrap).
    do_reset();
    drive(4'd5); drive(4'd13);
    check("rng_valid", int'(evt_valid), 1);
    check("rng_data", int'(evt_data), 8'hCD);
    check("rng_flag", int'(range_err), 1);
    drive(4'd0);
`ifdef MOD12_MON_JUMP_EN
    check("rng_next_valid", int'(evt_valid), 1);
    check("rng_next_data", int'(evt_data), 8'h80);
`else
    check("rng_next_valid", int'(evt_valid), 0);
`endif
    check("rng_next_wrap", int'(wrap_count), 0);
    check("rng_next_flag", int'(range_err), 0);
    drive(4'd0);

    // Overflow: 5 wraps into a 4-deep FIFO with the consumer stalled.
    do_reset();
    evt_ready = 1'b0;
    drive(4'd11);
    for (int i = 0; i < 5; i++) drive((i % 2 == 0) ? 4'd0 : 4'd11);
    check("ovf_wrap", int'(wrap_count), 5);
    check("ovf_drop", int'(drop_sticky), 1);
    check("ovf_head", int'(evt_data), 8'h00);
    drive(4'd0);
    check("ovf_hold", int'(evt_data), 8'h00);
    evt_ready = 1'b1;
    drive(4'd0); check("ovf_drain1", int'(evt_data), 8'h4B);
    drive(4'd0); check("ovf_drain2", int'(evt_data), 8'h00);
    drive(4'd0); check("ovf_drain3", int'(evt_data), 8'h4B);
    drive(4'd0); check("ovf_empty", int'(evt_valid), 0);
    check("ovf_drop_kept", int'(drop_sticky), 1);

    // Mid-operation reset discards queued events; first sample only primes.
    do_reset();
    evt_ready = 1'b0;
    drive(4'd11); drive(4'd0); drive(4'd11); drive(4'd0);
    check("mid_wrap", int'(wrap_count), 3);
    do_reset();
    check("mid_rst_valid", int'(evt_valid), 0);
    check("mid_rst_wrap", int'(wrap_count), 0);
    drive(4'd0);
    check("mid_first_sample", int'(evt_valid), 0);
    drive(4'd11);
    check("mid_second_sample", int'(evt_data), 8'h4B);

    // Saturation of the wrap counter.
    do_reset();
    evt_ready = 1'b1;
    drive(4'd11);
    for (int i = 0; i < 300; i++) drive((i % 2 == 0) ? 4'd0 : 4'd11);
    check("sat_wrap", int'(wrap_count), 255);

    // Directed mixed sequence with a stalling consumer pattern.
    do_reset();
    for (int i = 0; i < 120; i++) begin
      evt_ready = (i % 3 != 0);
      drive(4'((i * 7 + i / 5) % 16));
    end

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
